// File: rtl/hack_pkg.sv
// Shared types and widths for the Hack boot/run sequencer.
// HACK_HALT_DETECT_EN (see hack_boot_ctrl) enables the idle-loop detector.
package hack_pkg;

  localparam int INSTR_W         = 16;
  localparam int HACK_ROM_ADDR_W = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN,
    ST_HALT,
    ST_ERR
  } boot_state_t;

endpackage

// File: rtl/hack_halt_detect.sv
// Idle-loop detector: flags a halt once pc has repeated with period 1 or 2
// for HALT_CYCLES consecutive cycles. Only built under HACK_HALT_DETECT_EN.
module hack_halt_detect
  import hack_pkg::*;
#(
  parameter int HALT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic [INSTR_W-1:0] pc,
  output logic               halt
);

  localparam int CNT_W = $clog2(HALT_CYCLES + 1);

  logic [INSTR_W-1:0] pc_d1;
  logic [INSTR_W-1:0] pc_d2;
  logic               valid_d1;
  logic               valid_d2;
  logic [CNT_W-1:0]   hcnt;
  logic               match;

  // Comparing against pc two cycles back catches both a self-jump and a two-word loop.
  assign match = valid_d2 && (pc == pc_d2);
  assign halt  = match && (hcnt == CNT_W'(HALT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pc_d1    <= '0;
      pc_d2    <= '0;
      valid_d1 <= 1'b0;
      valid_d2 <= 1'b0;
      hcnt     <= '0;
    end else begin
      pc_d1    <= pc;
      pc_d2    <= pc_d1;
      valid_d1 <= 1'b1;
      valid_d2 <= valid_d1;
      hcnt     <= match ? hcnt + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/hack_boot_ctrl.sv
// Boot and run sequencer: streams a program into instruction ROM, then runs the CPU.
// Define HACK_HALT_DETECT_EN to build the idle-loop halt detector and HALT state.
module hack_boot_ctrl
  import hack_pkg::*;
#(
  parameter int ADDR_W      = HACK_ROM_ADDR_W,
  parameter int HALT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_last,
  output logic               rom_we,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic [INSTR_W-1:0] rom_wdata,
  input  logic [INSTR_W-1:0] pc,
  output logic               cpu_reset,
  output logic               done,
  output logic               err,
  output logic [31:0]        run_cycles
);

  boot_state_t       state;
  boot_state_t       next;
  logic [ADDR_W-1:0] wcnt;
  logic              hs;
  logic              load_entry;
  logic              halt;

`ifdef HACK_HALT_DETECT_EN
  hack_halt_detect #(
    .HALT_CYCLES(HALT_CYCLES)
  ) u_halt_detect (
    .clk  (clk),
    .reset(reset),
    .clr  (state != ST_RUN),
    .pc   (pc),
    .halt (halt)
  );
`else
  logic unused_cfg;
  assign halt       = 1'b0;
  assign done       = 1'b0;
  assign unused_cfg = (^pc) ^ (HALT_CYCLES > 0);
`endif

  assign in_ready   = (state == ST_LOAD);
  assign hs         = in_ready && in_valid;
  assign load_entry = (next == ST_LOAD) && (state != ST_LOAD);

  // start in RUN outranks a halt seen in the same cycle.
  always_comb begin
    next = state;
    case (state)
      ST_IDLE:  if (start) next = ST_LOAD;
      ST_LOAD: begin
        if (hs) begin
          if (in_last)         next = ST_FLUSH;
          else if (&wcnt)      next = ST_ERR;
        end
      end
      ST_FLUSH: next = ST_RUN;
      ST_RUN: begin
        if (start)             next = ST_LOAD;
        else if (halt)         next = ST_HALT;
      end
      ST_HALT:  if (start) next = ST_LOAD;
      ST_ERR:   if (start) next = ST_LOAD;
      default:  next = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cpu_reset  <= 1'b1;
      err        <= 1'b0;
`ifdef HACK_HALT_DETECT_EN
      done       <= 1'b0;
`endif
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      wcnt       <= '0;
      run_cycles <= '0;
    end else begin
      state     <= next;
      cpu_reset <= (next != ST_RUN);
      err       <= (next == ST_ERR);
`ifdef HACK_HALT_DETECT_EN
      done      <= (next == ST_HALT);
`endif
      rom_we    <= hs;
      if (hs) begin
        rom_addr  <= wcnt;
        rom_wdata <= in_data;
        wcnt      <= wcnt + 1'b1;
      end
      if (load_entry) begin
        wcnt       <= '0;
        run_cycles <= '0;
      end else if ((state == ST_RUN) && (run_cycles != 32'hFFFF_FFFF)) begin
        run_cycles <= run_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Randomized self-checking bench for hack_boot_ctrl (small ROM so overflow is reachable).
// Halt expectations follow HACK_HALT_DETECT_EN exactly as the DUT build does.
module tb_hack_boot_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int HC    = 3;
`ifdef HACK_HALT_DETECT_EN
  localparam bit DETECT = 1'b1;
`else
  localparam bit DETECT = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          in_last;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic [15:0]   pc;
  logic          cpu_reset;
  logic          done;
  logic          err;
  logic [31:0]   run_cycles;

  int          errors = 0;
  int          checks = 0;
  bit          loading;
  int          wordIdx;
  bit          inLoad;
  logic [15:0] prog[$];

  hack_boot_ctrl #(
    .ADDR_W(AW),
    .HALT_CYCLES(HC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .pc        (pc),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err),
    .run_cycles(run_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock with the inputs as driven; every write the loader caused must appear next cycle.
  task applyStimulus();
    bit            expWe;
    logic [AW-1:0] expAddr;
    logic [15:0]   expData;
    expWe   = loading && in_valid && !reset;
    expAddr = wordIdx[AW-1:0];
    expData = in_data;
    if (expWe) begin
      wordIdx++;
      if (in_last)                loading = 1'b0;
      else if (wordIdx == DEPTH)  loading = 1'b0;
    end
    @(negedge clk);
    checkOutput("rom_we", {31'd0, rom_we}, {31'd0, expWe});
    if (expWe) begin
      checkOutput("rom_addr", {29'd0, rom_addr}, {29'd0, expAddr});
      checkOutput("rom_wdata", {16'd0, rom_wdata}, {16'd0, expData});
    end
  endtask

  task checkResetValues();
    checkOutput("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_rom_addr", {29'd0, rom_addr}, 32'd0);
    checkOutput("rst_rom_wdata", {16'd0, rom_wdata}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_run_cycles", run_cycles, 32'd0);
  endtask

  task beginLoad();
    start = 1'b1;
    applyStimulus();
    start   = 1'b0;
    loading = 1'b1;
    wordIdx = 0;
    checkOutput("load_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("load_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("load_err", {31'd0, err}, 32'd0);
    checkOutput("load_done", {31'd0, done}, 32'd0);
    checkOutput("load_run_cycles", run_cycles, 32'd0);
  endtask

  // Streams the words in prog with random gaps; stray start pulses during LOAD must be ignored.
  task sendProgram(input bit withLast);
    int n;
    int gaps;
    n = prog.size();
    for (int i = 0; i < n; i++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        start    = ($urandom_range(0, 3) == 0);
        checkOutput("gap_in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus();
      end
      in_valid = 1'b1;
      in_data  = prog[i];
      in_last  = withLast && (i == n - 1);
      start    = ($urandom_range(0, 3) == 0);
      checkOutput("hs_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("hs_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      applyStimulus();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
  endtask

  task flushToRun();
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("flush_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("flush_err", {31'd0, err}, 32'd0);
    start = $urandom_range(0, 1);
    applyStimulus();
    start = 1'b0;
    checkOutput("run_entry_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    checkOutput("run_entry_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  // Reference: halt when the last HC cycles each had pc equal to pc two cycles earlier.
  task runProgram(input int prefix, input bit selfJump, input logic [15:0] loopBase,
                  input int abortAt, output bit endedInLoad);
    logic [15:0] hist[$];
    int          runCount;
    int          matchRun;
    bit          halting;
    bit          aborting;
    logic [15:0] pcv;
    hist.delete();
    runCount    = 0;
    matchRun    = 0;
    endedInLoad = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      checkOutput("run_cycles", run_cycles, runCount);
      checkOutput("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      checkOutput("run_done", {31'd0, done}, 32'd0);
      if (runCount < prefix)  pcv = 16'h0100 + 16'(runCount);
      else if (selfJump)      pcv = loopBase;
      else                    pcv = loopBase + 16'((runCount - prefix) % 2);
      hist.push_back(pcv);
      runCount++;
      if (runCount >= 3 && hist[runCount-1] == hist[runCount-3]) matchRun++;
      else matchRun = 0;
      aborting = (runCount == abortAt);
      halting  = DETECT && (matchRun >= HC) && !aborting;
      pc    = pcv;
      start = aborting;
      applyStimulus();
      start = 1'b0;
      if (aborting) begin
        loading     = 1'b1;
        wordIdx     = 0;
        endedInLoad = 1'b1;
        checkOutput("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("abort_run_cycles", run_cycles, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        return;
      end
      if (halting) begin
        checkOutput("halt_done", {31'd0, done}, 32'd1);
        checkOutput("halt_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("halt_run_cycles", run_cycles, runCount);
        for (int k = 0; k < 2; k++) begin
          pc = 16'($urandom);
          applyStimulus();
          checkOutput("halt_frozen", run_cycles, runCount);
          checkOutput("halt_done_hold", {31'd0, done}, 32'd1);
          checkOutput("halt_in_ready", {31'd0, in_ready}, 32'd0);
        end
        return;
      end
    end
    checkOutput("run_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int prefix;
    int len;
    int abortAt;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    pc       = '0;
    loading  = 1'b0;
    wordIdx  = 0;
    applyStimulus();
    applyStimulus();
    checkResetValues();
    reset = 1'b0;
    applyStimulus();
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd0);

    $display("[TB] directed load and 0/1 loop");
    beginLoad();
    prog = '{16'h0000, 16'hEA87};
    sendProgram(1'b1);
    flushToRun();
    runProgram(0, 1'b0, 16'h0000, 60, inLoad);

    $display("[TB] randomized programs");
    for (int it = 0; it < 8; it++) begin
      if (!inLoad) beginLoad();
      len = (it == 0) ? DEPTH : $urandom_range(1, DEPTH);
      prog.delete();
      for (int w = 0; w < len; w++) prog.push_back(16'($urandom));
      sendProgram(1'b1);
      flushToRun();
      prefix  = $urandom_range(0, 3);
      abortAt = (it % 2 == 1) ? $urandom_range(1, prefix + 2 + HC) : 60;
      if (it == 3) abortAt = prefix + 2 + HC;
      runProgram(prefix, $urandom_range(0, 1), 16'($urandom), abortAt, inLoad);
    end

    $display("[TB] overflow");
    if (!inLoad) beginLoad();
    prog.delete();
    for (int w = 0; w < DEPTH; w++) prog.push_back(16'($urandom));
    sendProgram(1'b0);
    checkOutput("ovf_err", {31'd0, err}, 32'd1);
    checkOutput("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("ovf_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    in_valid = 1'b1;
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("ovf_err_hold", {31'd0, err}, 32'd1);
    beginLoad();

    $display("[TB] reset mid-load");
    prog = '{16'h1111, 16'h2222, 16'h3333};
    sendProgram(1'b0);
    reset = 1'b1;
    applyStimulus();
    loading = 1'b0;
    checkResetValues();
    reset = 1'b0;
    applyStimulus();
    beginLoad();
    prog = '{16'hABCD, 16'h5A5A};
    sendProgram(1'b1);
    flushToRun();
    runProgram(1, 1'b1, 16'h0042, 20, inLoad);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
